// File: rtl/fft_out_reorder_if.sv
// ============================================================================
//  Module   : fft_out_reorder_if
//  Brief    : Input stream and output handshake bundle of the FFT reorder buffer.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface fft_out_reorder_if #(
    parameter int LOG2N = 3,
    parameter int W     = 8
);
    logic               din_valid;
    logic [2*W-1:0]     din;
    logic               dout_ready;
    logic               dout_valid;
    logic [2*W-1:0]     dout;
    logic [LOG2N-1:0]   dout_idx;
    logic               dout_last;

    // Master drives samples in and accepts reordered words out.
    modport master (
        output din_valid, din, dout_ready,
        input  dout_valid, dout, dout_idx, dout_last
    );

    modport slave (
        input  din_valid, din, dout_ready,
        output dout_valid, dout, dout_idx, dout_last
    );
endinterface

`default_nettype wire

// File: rtl/fft_out_reorder.sv
// ============================================================================
//  Module   : fft_out_reorder
//  Brief    : Ping-pong frame buffer turning bit-reversed FFT output into
//             natural bin order. FFT_OUT_REORDER_BITREV_EN enables bitrev
//             write addressing; undefined gives arrival-order passthrough.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module fft_out_reorder #(
    parameter int LOG2N = 3,
    parameter int W     = 8
) (
    input  wire          clk,
    input  wire          rstx,
    input  wire          clear,
    output logic         overflow,
    fft_out_reorder_if.slave bus
);

    localparam int               c_N    = 1 << LOG2N;
    localparam logic [LOG2N-1:0] c_LAST = LOG2N'(c_N - 1);

    logic [2*W-1:0]   r_mem [0:2*c_N-1];
    logic [1:0]       r_full;
    logic             r_wbank;
    logic             r_rbank;
    logic [LOG2N-1:0] r_wcnt;
    logic [LOG2N-1:0] r_rcnt;
    logic [2*W-1:0]   r_dout;
    logic [LOG2N-1:0] r_dout_idx;
    logic             r_dout_last;
    logic             r_dout_valid;
    logic             r_ovf;

    logic [LOG2N-1:0] w_waddr;
    logic             w_wr;
    logic             w_drop;
    logic             w_load;
    logic             w_rd;
    logic [1:0]       w_full_nxt;

`ifdef FFT_OUT_REORDER_BITREV_EN
    for (genvar i = 0; i < LOG2N; i++) begin : g_bitrev
        assign w_waddr[i] = r_wcnt[LOG2N-1-i];
    end
`else
    assign w_waddr = r_wcnt;
`endif

    assign w_wr   = bus.din_valid & ~clear & ~r_full[r_wbank];
    assign w_drop = bus.din_valid & ~clear &  r_full[r_wbank];
    assign w_load = ~r_dout_valid | bus.dout_ready;
    assign w_rd   = w_load & r_full[r_rbank];

    // Writer and reader always touch different banks, so both updates can coexist.
    always_comb begin
        w_full_nxt = r_full;
        if (w_wr && (r_wcnt == c_LAST)) begin
            w_full_nxt[r_wbank] = 1'b1;
        end
        if (w_rd && (r_rcnt == c_LAST)) begin
            w_full_nxt[r_rbank] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[{r_wbank, w_waddr}] <= bus.din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstx) begin
            r_full       <= '0;
            r_wbank      <= 1'b0;
            r_rbank      <= 1'b0;
            r_wcnt       <= '0;
            r_rcnt       <= '0;
            r_dout       <= '0;
            r_dout_idx   <= '0;
            r_dout_last  <= 1'b0;
            r_dout_valid <= 1'b0;
            r_ovf        <= 1'b0;
        end else if (clear) begin
            r_full       <= '0;
            r_wbank      <= 1'b0;
            r_rbank      <= 1'b0;
            r_wcnt       <= '0;
            r_rcnt       <= '0;
            r_dout_valid <= 1'b0;
            r_ovf        <= 1'b0;
        end else begin
            r_full <= w_full_nxt;
            if (w_wr) begin
                r_wcnt <= r_wcnt + 1'b1;
                if (r_wcnt == c_LAST) begin
                    r_wbank <= ~r_wbank;
                end
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
            if (w_load) begin
                if (r_full[r_rbank]) begin
                    r_dout       <= r_mem[{r_rbank, r_rcnt}];
                    r_dout_idx   <= r_rcnt;
                    r_dout_last  <= (r_rcnt == c_LAST);
                    r_dout_valid <= 1'b1;
                    r_rcnt       <= r_rcnt + 1'b1;
                    if (r_rcnt == c_LAST) begin
                        r_rbank <= ~r_rbank;
                    end
                end else begin
                    r_dout_valid <= 1'b0;
                end
            end
        end
    end

    assign bus.dout       = r_dout;
    assign bus.dout_idx   = r_dout_idx;
    assign bus.dout_last  = r_dout_last;
    assign bus.dout_valid = r_dout_valid;
    assign overflow       = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_fft_out_reorder.sv
// ============================================================================
//  Module   : tb_fft_out_reorder
//  Brief    : Randomized bench for fft_out_reorder against a queue-based frame model.
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fft_out_reorder;

    localparam int LOG2N = 3;
    localparam int N     = 8;
    localparam int W     = 8;

    logic clk = 1'b0;
    logic rstx;
    logic clear;
    logic overflow;

    always #5 clk = ~clk;

    fft_out_reorder_if #(.LOG2N(LOG2N), .W(W)) bus ();

    fft_out_reorder #(.LOG2N(LOG2N), .W(W)) dut (
        .clk      (clk),
        .rstx     (rstx),
        .clear    (clear),
        .overflow (overflow),
        .bus      (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: completed frames flattened in arrival order, plus the frame being filled.
    logic [15:0] m_full[$];
    logic [15:0] m_part[$];
    int          m_rpos;
    logic        m_valid;
    logic        m_last;
    logic        m_ovf;
    logic [15:0] m_dout;
    logic [2:0]  m_idx;

    logic [15:0] acc[$];
    int          exp_re[N];

    function automatic int src_pos(input int j);
        int r;
`ifdef FFT_OUT_REORDER_BITREV_EN
        r = 0;
        for (int b = 0; b < LOG2N; b++) begin
            if (((j >> b) & 1) != 0) r = r | (1 << (LOG2N - 1 - b));
        end
`else
        r = j;
`endif
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic v, input logic [15:0] d, input logic rdy,
                              input logic clr, input logic rst);
        int nfull;
        if (!rst) begin
            m_full.delete(); m_part.delete(); m_rpos = 0;
            m_valid = 0; m_dout = 0; m_idx = 0; m_last = 0; m_ovf = 0;
        end else if (clr) begin
            m_full.delete(); m_part.delete(); m_rpos = 0;
            m_valid = 0; m_ovf = 0;
        end else begin
            nfull = m_full.size() / N;
            if (!m_valid || rdy) begin
                if (nfull > 0) begin
                    m_dout  = m_full[src_pos(m_rpos)];
                    m_idx   = 3'(m_rpos);
                    m_last  = (m_rpos == N - 1);
                    m_valid = 1;
                    m_rpos++;
                    if (m_rpos == N) begin
                        repeat (N) void'(m_full.pop_front());
                        m_rpos = 0;
                    end
                end else begin
                    m_valid = 0;
                end
            end
            if (v) begin
                if (nfull == 2) begin
                    m_ovf = 1;
                end else begin
                    m_part.push_back(d);
                    if (m_part.size() == N) begin
                        foreach (m_part[i]) m_full.push_back(m_part[i]);
                        m_part.delete();
                    end
                end
            end
        end
    endtask

    task automatic cycle(input logic v, input logic [15:0] d, input logic rdy,
                         input logic clr, input logic rst);
        logic        pre_valid;
        logic [15:0] pre_dout;
        bus.din_valid  = v;
        bus.din        = d;
        bus.dout_ready = rdy;
        clear          = clr;
        rstx           = rst;
        pre_valid      = bus.dout_valid;
        pre_dout       = bus.dout;
        @(posedge clk);
        if (rst && !clr && pre_valid === 1'b1 && rdy) acc.push_back(pre_dout);
        model_step(v, d, rdy, clr, rst);
        #1;
        check("dout_valid", 32'(bus.dout_valid), 32'(m_valid));
        check("overflow",   32'(overflow),       32'(m_ovf));
        check("dout",       32'(bus.dout),       32'(m_dout));
        check("dout_idx",   32'(bus.dout_idx),   32'(m_idx));
        check("dout_last",  32'(bus.dout_last),  32'(m_last));
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
    endtask

    initial begin
`ifdef FFT_OUT_REORDER_BITREV_EN
        exp_re = '{0, 4, 2, 6, 1, 5, 3, 7};
`else
        exp_re = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif
        bus.din_valid = 0; bus.din = 0; bus.dout_ready = 1; clear = 0; rstx = 0;

        // Reset held with input activity
        repeat (4) begin
            cycle(1'b1, 16'($urandom), 1'b1, 1'b0, 1'b0);
            check("rst_dout", 32'(bus.dout), 32'h0);
            check("rst_valid", 32'(bus.dout_valid), 32'h0);
        end
        idle(6);
        check("post_rst_valid", 32'(bus.dout_valid), 32'h0);

        // Single frame
        acc.delete();
        for (int k = 0; k < N; k++) cycle(1'b1, 16'(k), 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
        check("lat_valid", 32'(bus.dout_valid), 32'h1);
        check("lat_idx", 32'(bus.dout_idx), 32'h0);
        idle(10);
        check("single_cnt", acc.size(), 8);
        for (int j = 0; j < N; j++) begin
            logic [15:0] w;
            w = (j < acc.size()) ? acc[j] : 16'hFFFF;
            check("single_re", 32'(w), 32'(exp_re[j]));
        end

        // Continuous three frames
        acc.delete();
        repeat (24) cycle(1'b1, 16'($urandom), 1'b1, 1'b0, 1'b1);
        idle(12);
        check("cont_cnt", acc.size(), 24);
        check("cont_ovf", 32'(overflow), 32'h0);

        // Gapped input, 2 on / 2 off
        acc.delete();
        for (int i = 0; i < 16; i++) cycle(((i % 4) < 2), 16'($urandom), 1'b1, 1'b0, 1'b1);
        idle(12);
        check("gap_cnt", acc.size(), 8);

        // Backpressure fills both banks then drops
        acc.delete();
        repeat (24) cycle(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b1);
        check("bp_ovf", 32'(overflow), 32'h1);
        idle(20);
        check("bp_cnt", acc.size(), 16);
        check("bp_ovf_sticky", 32'(overflow), 32'h1);

        // Clear mid-frame
        cycle(1'b0, 16'h0, 1'b1, 1'b1, 1'b1);
        acc.delete();
        repeat (5) cycle(1'b1, 16'($urandom), 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 16'hBEEF, 1'b1, 1'b1, 1'b1);
        for (int k = 0; k < N; k++) cycle(1'b1, (k < 4) ? 16'h0040 : 16'h0000, 1'b1, 1'b0, 1'b1);
        idle(12);
        check("clr_cnt", acc.size(), 8);
        check("clr_ovf", 32'(overflow), 32'h0);
        check("clr_w0", 32'((acc.size() > 0) ? acc[0] : 16'hFFFF), 32'h0040);
`ifdef FFT_OUT_REORDER_BITREV_EN
        check("clr_w1", 32'((acc.size() > 1) ? acc[1] : 16'hFFFF), 32'h0000);
`else
        check("clr_w1", 32'((acc.size() > 1) ? acc[1] : 16'hFFFF), 32'h0040);
`endif

        // Randomized traffic with stalls, clears and resets
        for (int i = 0; i < 3000; i++) begin
            logic v, rdy, clr, rst;
            v   = ($urandom % 4) != 0;
            rdy = (($urandom % 3) != 0) && ((i % 300) >= 40);
            clr = ($urandom % 200) == 0;
            rst = ($urandom % 500) != 0;
            cycle(v, 16'($urandom), rdy, clr, rst);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
